// File: rtl/paralelo_serial.sv
// Byte-to-serial PHY transmitter: a 4-byte comma training burst after reset, then one byte per 8-cycle slot, MSB first.
// Latency: a byte sampled at load edge E drives its MSB after E and its LSB after E+7.
// Backpressure: no buffering; ready_out pulses one cycle in eight, and a byte not presented at that load is dropped.
// Optional: define PS_BC_ERR_EN to add the sticky err_bc flag, set when a valid data byte equals the idle/comma byte.
module paralelo_serial #(
    parameter logic [7:0] IDLE_BYTE   = 8'hBC,
    parameter int         TRAIN_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active_tx
`ifdef PS_BC_ERR_EN
    ,
    output logic       err_bc
`endif
);

    typedef enum logic {
        ST_TRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Training count of the final comma; the transition to RUN happens on that load.
    localparam logic [3:0] TRAIN_LAST = 4'(TRAIN_COUNT - 1);

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [3:0] train_cnt_q, train_cnt_d;
    logic       data_out_q, data_out_d;
    logic       ready_q, ready_d;
    logic       active_q, active_d;
    logic [7:0] byte_sel;
    logic       load;
`ifdef PS_BC_ERR_EN
    logic       err_q, err_d;
`endif

    // Slot sequencing: pick the byte at a load edge, otherwise keep shifting the current one out.
    always_comb begin
        bit_cnt_d   = bit_cnt_q + 3'd1;
        shreg_d     = {shreg_q[6:0], 1'b0};
        data_out_d  = shreg_q[7];
        train_cnt_d = train_cnt_q;
        state_d     = state_q;
        active_d    = active_q;
        byte_sel    = IDLE_BYTE;
        load        = (bit_cnt_q == 3'd7);
`ifdef PS_BC_ERR_EN
        err_d       = err_q;
`endif
        if (load) begin
            if (state_q == ST_TRAIN) begin
                // Commas only; anything on the parallel side is ignored while training.
                train_cnt_d = train_cnt_q + 4'd1;
                if (train_cnt_q == TRAIN_LAST) begin
                    state_d  = ST_RUN;
                    active_d = 1'b1;
                end
            end else if (valid_in) begin
                byte_sel = data_in;
`ifdef PS_BC_ERR_EN
                // A data byte that looks like a comma is sent anyway; the receiver will lose it.
                if (data_in == IDLE_BYTE) begin
                    err_d = 1'b1;
                end
`endif
            end
            data_out_d = byte_sel[7];
            shreg_d    = {byte_sel[6:0], 1'b0};
        end
        // ready_out covers exactly the cycle that precedes a RUN load edge.
        ready_d = (bit_cnt_q == 3'd6) && (state_d == ST_RUN);
    end

    // State registers with synchronous active-high reset; a reset abandons any partial byte.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q     <= ST_TRAIN;
            bit_cnt_q   <= 3'd7;
            shreg_q     <= 8'h00;
            train_cnt_q <= 4'd0;
            data_out_q  <= 1'b0;
            ready_q     <= 1'b0;
            active_q    <= 1'b0;
`ifdef PS_BC_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            train_cnt_q <= train_cnt_d;
            data_out_q  <= data_out_d;
            ready_q     <= ready_d;
            active_q    <= active_d;
`ifdef PS_BC_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    assign data_out  = data_out_q;
    assign ready_out = ready_q;
    assign active_tx = active_q;
`ifdef PS_BC_ERR_EN
    assign err_bc    = err_q;
`endif

endmodule
